// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if -- bundle of the two requester ports and the data-memory
// port of the shared data-memory arbiter.
//
// Requester side (per port N = 0/1):
//   reqN, weN, addrN[31:0], wdataN[31:0]   request, held stable until gntN
//   gntN                                    request accepted this cycle
//   rvalidN, rdataN[31:0], errN             one-cycle response pulse
// Memory side:
//   mem_we, mem_a[31:0], mem_di[31:0]       write enable / address / data
//   mem_rd[31:0]                            combinational read data
//
// Modports: master = requesters plus memory (environment side),
//           slave  = the arbiter itself.
interface dmem_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        gnt0;
    logic        gnt1;
    logic        rvalid0;
    logic        rvalid1;
    logic [31:0] rdata0;
    logic [31:0] rdata1;
    logic        err0;
    logic        err1;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_di;
    logic [31:0] mem_rd;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
        input  mem_we, mem_a, mem_di,
        output mem_rd
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1,
        output mem_we, mem_a, mem_di,
        input  mem_rd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter -- two-port round-robin arbiter in front of a single-ported
// 32-bit data memory of DEPTH words.
//
// Ports:
//   clk   sole clock, all state updates on posedge
//   rst   synchronous active-high reset
//   bus   dmem_arbiter_if.slave: two request/response ports plus the
//         memory port (mem_we/mem_a/mem_di out, mem_rd in)
//
// Grants are combinational; every grant produces exactly one response pulse
// on the following cycle. Out-of-range or misaligned requests are granted
// but never touch memory and answer with err=1, rdata=0.
module dmem_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    // A word address is legal when it is aligned and every bit above the
    // word index is zero.
    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] hi;
        hi = a >> (AW + 2);
        return (hi == 32'd0) && (a[1:0] == 2'b00);
    endfunction

    logic        last_gnt_q, last_gnt_d;
    logic        rvalid0_q, rvalid0_d;
    logic        rvalid1_q, rvalid1_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        err0_q, err0_d;
    logic        err1_q, err1_d;

    logic        gnt0_c, gnt1_c, any_gnt;
    logic        sel_we, sel_ok;
    logic [31:0] sel_addr, sel_wdata;
    logic        mem_we_c;
    logic [31:0] mem_a_c, mem_di_c;
    logic [31:0] resp_data;
    logic        resp_err;

    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (!rst) begin
            if (bus.req0 && bus.req1) begin
                // Contention: the port that did not win last time goes now.
                if (last_gnt_q) gnt0_c = 1'b1;
                else            gnt1_c = 1'b1;
            end else begin
                gnt0_c = bus.req0;
                gnt1_c = bus.req1;
            end
        end
        any_gnt = gnt0_c | gnt1_c;

        sel_we    = gnt1_c ? bus.we1    : bus.we0;
        sel_addr  = gnt1_c ? bus.addr1  : bus.addr0;
        sel_wdata = gnt1_c ? bus.wdata1 : bus.wdata0;
        sel_ok    = in_range(sel_addr);

        mem_we_c = any_gnt & sel_we & sel_ok;
        mem_a_c  = any_gnt  ? sel_addr  : 32'd0;
        mem_di_c = mem_we_c ? sel_wdata : 32'd0;

        // Writes and rejected requests answer with zero data.
        resp_data = (any_gnt && !sel_we && sel_ok) ? bus.mem_rd : 32'd0;
        resp_err  = any_gnt & ~sel_ok;

        last_gnt_d = last_gnt_q;
        if (gnt0_c) last_gnt_d = 1'b0;
        if (gnt1_c) last_gnt_d = 1'b1;

        rvalid0_d = gnt0_c;
        rvalid1_d = gnt1_c;
        rdata0_d  = gnt0_c ? resp_data : rdata0_q;
        rdata1_d  = gnt1_c ? resp_data : rdata1_q;
        err0_d    = gnt0_c & resp_err;
        err1_d    = gnt1_c & resp_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= 1'b1;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= 32'd0;
            rdata1_q   <= 32'd0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
        end else begin
            last_gnt_q <= last_gnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
        end
    end

    assign bus.gnt0   = gnt0_c;
    assign bus.gnt1   = gnt1_c;
    assign bus.mem_we = mem_we_c;
    assign bus.mem_a  = mem_a_c;
    assign bus.mem_di = mem_di_c;

    // A response left over from the cycle before reset must not escape
    // while reset is being held.
    assign bus.rvalid0 = rvalid0_q & ~rst;
    assign bus.rvalid1 = rvalid1_q & ~rst;
    assign bus.err0    = err0_q & ~rst;
    assign bus.err1    = err1_q & ~rst;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter -- directed testbench for dmem_arbiter (DEPTH=4) with a
// small behavioural data memory attached to the memory port.
module tb_dmem_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    dmem_arbiter_if bus();

    dmem_arbiter #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural memory: combinational read, write at posedge.
    logic [31:0] mem_model [0:3];
    logic        mem_loaded = 1'b0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            mem_model[0] <= 32'h1111_1111;
            mem_model[1] <= 32'h2222_2222;
            mem_model[2] <= 32'h3333_3333;
            mem_model[3] <= 32'h4444_4444;
            mem_loaded   <= 1'b1;
        end else if (bus.mem_we) begin
            mem_model[bus.mem_a[3:2]] <= bus.mem_di;
        end
    end

    assign bus.mem_rd = mem_model[bus.mem_a[3:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1);
    end

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 32'd0; bus.wdata0 = 32'd0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 32'd0; bus.wdata1 = 32'd0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h0;  bus.wdata0 = 32'hAAAA_0000;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h4;  bus.wdata1 = 32'hBBBB_0000;
        #1;
        checks++; if (bus.gnt0 !== 1'b0) begin failures++; $display("FAIL reset_gnt0 got=%b exp=0", bus.gnt0); end
        checks++; if (bus.gnt1 !== 1'b0) begin failures++; $display("FAIL reset_gnt1 got=%b exp=0", bus.gnt1); end
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", bus.mem_we); end
        @(negedge clk);
        #1;
        checks++; if (bus.rvalid0 !== 1'b0) begin failures++; $display("FAIL reset_rvalid0 got=%b exp=0", bus.rvalid0); end
        checks++; if (bus.rvalid1 !== 1'b0) begin failures++; $display("FAIL reset_rvalid1 got=%b exp=0", bus.rvalid1); end
        checks++; if (bus.rdata0 !== 32'd0) begin failures++; $display("FAIL reset_rdata0 got=%h exp=0", bus.rdata0); end
        checks++; if (bus.rdata1 !== 32'd0) begin failures++; $display("FAIL reset_rdata1 got=%h exp=0", bus.rdata1); end
        checks++; if (bus.err0 !== 1'b0) begin failures++; $display("FAIL reset_err0 got=%b exp=0", bus.err0); end
        checks++; if (bus.err1 !== 1'b0) begin failures++; $display("FAIL reset_err1 got=%b exp=0", bus.err1); end
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_write();
        @(negedge clk);
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h8; bus.wdata0 = 32'h0000_0005;
        #1;
        checks++; if (bus.gnt0 !== 1'b1) begin failures++; $display("FAIL wr_gnt0 got=%b exp=1", bus.gnt0); end
        checks++; if (bus.gnt1 !== 1'b0) begin failures++; $display("FAIL wr_gnt1 got=%b exp=0", bus.gnt1); end
        checks++; if (bus.mem_we !== 1'b1) begin failures++; $display("FAIL wr_mem_we got=%b exp=1", bus.mem_we); end
        checks++; if (bus.mem_a !== 32'h8) begin failures++; $display("FAIL wr_mem_a got=%h exp=8", bus.mem_a); end
        checks++; if (bus.mem_di !== 32'h5) begin failures++; $display("FAIL wr_mem_di got=%h exp=5", bus.mem_di); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (bus.rvalid0 !== 1'b1) begin failures++; $display("FAIL wr_rvalid0 got=%b exp=1", bus.rvalid0); end
        checks++; if (bus.err0 !== 1'b0) begin failures++; $display("FAIL wr_err0 got=%b exp=0", bus.err0); end
        checks++; if (bus.rdata0 !== 32'd0) begin failures++; $display("FAIL wr_rdata0 got=%h exp=0", bus.rdata0); end
        checks++; if (bus.rvalid1 !== 1'b0) begin failures++; $display("FAIL wr_rvalid1 got=%b exp=0", bus.rvalid1); end
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL idle_mem_we got=%b exp=0", bus.mem_we); end
        checks++; if (bus.mem_a !== 32'd0) begin failures++; $display("FAIL idle_mem_a got=%h exp=0", bus.mem_a); end
        checks++; if (mem_model[2] !== 32'h5) begin failures++; $display("FAIL wr_mem_word2 got=%h exp=5", mem_model[2]); end
    endtask

    task automatic test_read();
        @(negedge clk);
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h8;
        #1;
        checks++; if (bus.gnt1 !== 1'b1) begin failures++; $display("FAIL rd_gnt1 got=%b exp=1", bus.gnt1); end
        checks++; if (bus.gnt0 !== 1'b0) begin failures++; $display("FAIL rd_gnt0 got=%b exp=0", bus.gnt0); end
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rd_mem_we got=%b exp=0", bus.mem_we); end
        checks++; if (bus.mem_a !== 32'h8) begin failures++; $display("FAIL rd_mem_a got=%h exp=8", bus.mem_a); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (bus.rvalid1 !== 1'b1) begin failures++; $display("FAIL rd_rvalid1 got=%b exp=1", bus.rvalid1); end
        checks++; if (bus.rdata1 !== 32'h5) begin failures++; $display("FAIL rd_rdata1 got=%h exp=5", bus.rdata1); end
        checks++; if (bus.err1 !== 1'b0) begin failures++; $display("FAIL rd_err1 got=%b exp=0", bus.err1); end
        @(negedge clk);
        #1;
        checks++; if (bus.rvalid1 !== 1'b0) begin failures++; $display("FAIL hold_rvalid1 got=%b exp=0", bus.rvalid1); end
        checks++; if (bus.rdata1 !== 32'h5) begin failures++; $display("FAIL hold_rdata1 got=%h exp=5", bus.rdata1); end
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h10; bus.wdata0 = 32'hDEAD_BEEF;
        #1;
        checks++; if (bus.gnt0 !== 1'b1) begin failures++; $display("FAIL oor_gnt0 got=%b exp=1", bus.gnt0); end
        checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL oor_mem_we got=%b exp=0", bus.mem_we); end
        @(negedge clk);
        idle_inputs();
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h6;
        #1;
        checks++; if (bus.rvalid0 !== 1'b1) begin failures++; $display("FAIL oor_rvalid0 got=%b exp=1", bus.rvalid0); end
        checks++; if (bus.err0 !== 1'b1) begin failures++; $display("FAIL oor_err0 got=%b exp=1", bus.err0); end
        checks++; if (bus.rdata0 !== 32'd0) begin failures++; $display("FAIL oor_rdata0 got=%h exp=0", bus.rdata0); end
        checks++; if (bus.gnt1 !== 1'b1) begin failures++; $display("FAIL misalign_gnt1 got=%b exp=1", bus.gnt1); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (bus.rvalid1 !== 1'b1) begin failures++; $display("FAIL misalign_rvalid1 got=%b exp=1", bus.rvalid1); end
        checks++; if (bus.err1 !== 1'b1) begin failures++; $display("FAIL misalign_err1 got=%b exp=1", bus.err1); end
        checks++; if (bus.rdata1 !== 32'd0) begin failures++; $display("FAIL misalign_rdata1 got=%h exp=0", bus.rdata1); end
        checks++; if (bus.err0 !== 1'b0) begin failures++; $display("FAIL oor_err0_idle got=%b exp=0", bus.err0); end
        checks++; if (mem_model[0] !== 32'h1111_1111) begin failures++; $display("FAIL oor_mem_word0 got=%h exp=11111111", mem_model[0]); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h4; bus.wdata0 = 32'h0000_000A;
        #1;
        checks++; if (bus.gnt0 !== 1'b1) begin failures++; $display("FAIL b2b_wr_gnt0 got=%b exp=1", bus.gnt0); end
        checks++; if (bus.mem_we !== 1'b1) begin failures++; $display("FAIL b2b_wr_mem_we got=%b exp=1", bus.mem_we); end
        @(negedge clk);
        bus.we0 = 1'b0;
        #1;
        checks++; if (bus.rvalid0 !== 1'b1) begin failures++; $display("FAIL b2b_wr_rvalid0 got=%b exp=1", bus.rvalid0); end
        checks++; if (bus.rdata0 !== 32'd0) begin failures++; $display("FAIL b2b_wr_rdata0 got=%h exp=0", bus.rdata0); end
        checks++; if (bus.gnt0 !== 1'b1) begin failures++; $display("FAIL b2b_rd_gnt0 got=%b exp=1", bus.gnt0); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (bus.rvalid0 !== 1'b1) begin failures++; $display("FAIL b2b_rd_rvalid0 got=%b exp=1", bus.rvalid0); end
        checks++; if (bus.rdata0 !== 32'h0000_000A) begin failures++; $display("FAIL b2b_rd_rdata0 got=%h exp=0000000a", bus.rdata0); end
        checks++; if (bus.err0 !== 1'b0) begin failures++; $display("FAIL b2b_rd_err0 got=%b exp=0", bus.err0); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g0;
        logic [3:0] exp_g1;
        exp_g0 = 4'b0101;   // bit i = expected gnt0 in cycle i
        exp_g1 = 4'b1010;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'h8;
            bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h4;
            #1;
            checks++; if (bus.gnt0 !== exp_g0[i]) begin failures++; $display("FAIL rr_gnt0 cycle=%0d got=%b exp=%b", i, bus.gnt0, exp_g0[i]); end
            checks++; if (bus.gnt1 !== exp_g1[i]) begin failures++; $display("FAIL rr_gnt1 cycle=%0d got=%b exp=%b", i, bus.gnt1, exp_g1[i]); end
            if (i > 0) begin
                checks++; if (bus.rvalid0 !== exp_g0[i-1]) begin failures++; $display("FAIL rr_rvalid0 cycle=%0d got=%b exp=%b", i, bus.rvalid0, exp_g0[i-1]); end
                checks++; if (bus.rvalid1 !== exp_g1[i-1]) begin failures++; $display("FAIL rr_rvalid1 cycle=%0d got=%b exp=%b", i, bus.rvalid1, exp_g1[i-1]); end
            end else begin
                checks++; if ((bus.rvalid0 | bus.rvalid1) !== 1'b0) begin failures++; $display("FAIL rr_no_rvalid_first got=%b%b exp=00", bus.rvalid0, bus.rvalid1); end
            end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (bus.rvalid1 !== 1'b1) begin failures++; $display("FAIL rr_last_rvalid1 got=%b exp=1", bus.rvalid1); end
        checks++; if (bus.rvalid0 !== 1'b0) begin failures++; $display("FAIL rr_last_rvalid0 got=%b exp=0", bus.rvalid0); end
        checks++; if (bus.rdata1 !== 32'h0000_000A) begin failures++; $display("FAIL rr_rdata1 got=%h exp=0000000a", bus.rdata1); end
        checks++; if (bus.rdata0 !== 32'h0000_0005) begin failures++; $display("FAIL rr_rdata0 got=%h exp=00000005", bus.rdata0); end
    endtask

    task automatic test_reset_during_traffic();
        apply_reset();
        @(negedge clk);
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'hC; bus.wdata0 = 32'h0000_0077;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'h8;
        #1;
        checks++; if (bus.gnt0 !== 1'b1) begin failures++; $display("FAIL rst_pre_gnt0 got=%b exp=1", bus.gnt0); end
        checks++; if (bus.mem_we !== 1'b1) begin failures++; $display("FAIL rst_pre_mem_we got=%b exp=1", bus.mem_we); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            rst = 1'b1;
            #1;
            checks++; if ((bus.gnt0 | bus.gnt1) !== 1'b0) begin failures++; $display("FAIL rst_gnt cycle=%0d got=%b%b exp=00", k, bus.gnt0, bus.gnt1); end
            checks++; if ((bus.rvalid0 | bus.rvalid1) !== 1'b0) begin failures++; $display("FAIL rst_rvalid cycle=%0d got=%b%b exp=00", k, bus.rvalid0, bus.rvalid1); end
            checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we cycle=%0d got=%b exp=0", k, bus.mem_we); end
        end
        checks++; if (mem_model[3] !== 32'h0000_0077) begin failures++; $display("FAIL rst_committed_write got=%h exp=00000077", mem_model[3]); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.gnt0 !== 1'b1) begin failures++; $display("FAIL rst_post_gnt0 got=%b exp=1", bus.gnt0); end
        checks++; if (bus.gnt1 !== 1'b0) begin failures++; $display("FAIL rst_post_gnt1 got=%b exp=0", bus.gnt1); end
        checks++; if ((bus.rvalid0 | bus.rvalid1) !== 1'b0) begin failures++; $display("FAIL rst_post_rvalid got=%b%b exp=00", bus.rvalid0, bus.rvalid1); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (bus.rvalid0 !== 1'b1) begin failures++; $display("FAIL rst_post_resp_rvalid0 got=%b exp=1", bus.rvalid0); end
        checks++; if (bus.err0 !== 1'b0) begin failures++; $display("FAIL rst_post_resp_err0 got=%b exp=0", bus.err0); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_write();
        test_read();
        test_out_of_range();
        test_back_to_back();
        test_round_robin();
        test_reset_during_traffic();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
